pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the 2x clock wizard and is clocked by its clk_out1 (202 MHz).
- Consumes the wizard's asynchronous locked indication.
- Produces ordered, synchronously released active-low resets for the fast-domain core and peripherals, plus a ready flag.
- Re-asserts all resets on PLL lock loss or a software reset request.

Parameters:
SYNC_STAGES, 2, depth of the locked synchronizer; minimum 2.
STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before core reset release; 1 to 2^CNT_W-1.
STAGE_DELAY, 16, cycles between successive release stages and soft-reset hold length; 1 to 2^CNT_W-1.
CNT_W, 16, width of the shared cycle counter.

Ports:
clk_in1  input  1  fast clock, driven from the wizard clk_out1
resetn  input  1  asynchronous active-low reset
locked  input  1  PLL lock from the wizard; asynchronous to clk_in1
soft_rst_req  input  1  synchronous level; requests re-sequencing of core and peripheral resets
core_rstn  output  1  active-low core reset, registered
periph_rstn  output  1  active-low peripheral reset, registered
ready  output  1  high when fully out of reset, registered
state_o  output  3  current FSM state encoding, for debug

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous and active-low.
- resetn low: asynchronously forces core_rstn=0, periph_rstn=0, ready=0, state=S_HOLD, counter=0, and all synchronizer flops to 0.
- Synchronizer: locked passes through a SYNC_STAGES flop chain to lock_s. locked first sampled high at edge 1 gives lock_s=1 after edge SYNC_STAGES.
- All outputs are registered and decoded from the next state, so each changes on the edge the state is entered.
- State encoding: S_HOLD=0, S_STABLE=1, S_CORE=2, S_PERIPH=3, S_RUN=4, S_SOFT=5. Encodings 6 and 7 recover to S_HOLD.
- S_HOLD: all outputs 0. If lock_s=1, go to S_STABLE with cnt=0.
- S_STABLE: all outputs 0.
  - lock_s=0: go to S_HOLD, cnt=0.
  - cnt==STABLE_CYCLES-1: go to S_CORE, cnt=0.
  - Otherwise cnt+1.
- S_CORE: core_rstn=1. At cnt==STAGE_DELAY-1 go to S_PERIPH, cnt=0.
- S_PERIPH: core_rstn=1, periph_rstn=1. At cnt==STAGE_DELAY-1 go to S_RUN, cnt=0.
- S_RUN: core_rstn=1, periph_rstn=1, ready=1. Holds indefinitely.
- S_SOFT: all outputs 0. While soft_rst_req=1, cnt is held at 0. Otherwise at cnt==STAGE_DELAY-1 go to S_CORE, cnt=0, else cnt+1.
- Release timing: core_rstn rises at edge SYNC_STAGES+1+STABLE_CYCLES; periph_rstn STAGE_DELAY edges later; ready another STAGE_DELAY edges later.
- Priority, highest first: resetn, then lock loss (lock_s=0 in any state except S_HOLD), then soft_rst_req, then counter completion.
  - Lock loss: go to S_HOLD; all outputs 0 on the next edge.
  - soft_rst_req=1: honoured only in S_CORE, S_PERIPH and S_RUN. Go to S_SOFT, cnt=0. Ignored in S_HOLD and S_STABLE.
- Lock-loss latency: locked low first sampled at edge k gives outputs 0 at edge k+SYNC_STAGES.
- Glitch rule: a locked low pulse shorter than one clk_in1 period may be missed; this is acceptable. Any pulse reaching lock_s fully restarts the STABLE_CYCLES count.
- Counter: never wraps; it is cleared on every state transition.
- Release order is strictly core_rstn, then periph_rstn, then ready. Assertion (drop to 0) is simultaneous on all three.

Optional Feature:
- Macro: LOCK_LOSS_COUNTER_EN.
- Defined: adds output port lock_loss_cnt (input-less, output, 8 bits).
  - Increments by 1 on every lock-loss transition into S_HOLD, from any state other than S_HOLD.
  - Saturates at 255. Not incremented by soft resets. Cleared only by resetn.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Params SYNC_STAGES=2, STABLE_CYCLES=8, STAGE_DELAY=4. resetn released, locked=1 from edge 1 -> core_rstn rises at edge 11, periph_rstn at edge 15, ready at edge 19; state_o steps 0,1,2,3,4.
- locked drops for 3 cycles during S_STABLE at count 5, then returns high -> state returns to 0; core_rstn release is delayed by the full 8-cycle count after lock_s re-asserts.
- In S_RUN, locked low first sampled at edge k -> core_rstn, periph_rstn and ready all 0 at edge k+2; state_o=0.
- In S_RUN, soft_rst_req high for 6 cycles -> outputs 0 on the next edge; core_rstn rises 4 edges after soft_rst_req falls, then periph_rstn +4, then ready +4.
- resetn pulsed low mid-S_PERIPH -> outputs 0 immediately without a clock edge; full sequence restarts from S_HOLD.
- LOCK_LOSS_COUNTER_EN defined, 3 lock losses plus 1 soft reset -> lock_loss_cnt=3. Forced 300 losses -> lock_loss_cnt=255.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// Qualifies the wizard's asynchronous lock and releases core, then peripheral resets, then ready.
// Define LOCK_LOSS_COUNTER_EN to add the saturating lock_loss_cnt output.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int STAGE_DELAY   = 16,
  parameter int CNT_W         = 16
) (
  input  logic       clk_in1,
  input  logic       resetn,
  input  logic       locked,
  input  logic       soft_rst_req,
  output logic       core_rstn,
  output logic       periph_rstn,
  output logic       ready,
  output logic [2:0] state_o
`ifdef LOCK_LOSS_COUNTER_EN
  ,
  output logic [7:0] lock_loss_cnt
`endif
);

  localparam logic [2:0] S_HOLD   = 3'd0;
  localparam logic [2:0] S_STABLE = 3'd1;
  localparam logic [2:0] S_CORE   = 3'd2;
  localparam logic [2:0] S_PERIPH = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;
  localparam logic [2:0] S_SOFT   = 3'd5;

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST  = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  logic                   lock_s;

  logic [2:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             lock_lost;
  logic             core_next, periph_next, ready_next;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_next[gi] = locked;
      end else begin : g_chain
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk_in1 or negedge resetn) begin
    if (!resetn) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= sync_next;
    end
  end

  assign lock_s = sync_reg[SYNC_STAGES-1];

  // Lock loss outranks everything except resetn, including unused encodings.
  assign lock_lost = !lock_s && (state_reg != S_HOLD);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (lock_lost) begin
      state_next = S_HOLD;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        S_HOLD: begin
          cnt_next = '0;
          if (lock_s) begin
            state_next = S_STABLE;
          end
        end
        S_STABLE: begin
          if (cnt_reg == STABLE_LAST) begin
            state_next = S_CORE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
        S_CORE, S_PERIPH: begin
          if (soft_rst_req) begin
            state_next = S_SOFT;
            cnt_next   = '0;
          end else if (cnt_reg == STAGE_LAST) begin
            state_next = (state_reg == S_CORE) ? S_PERIPH : S_RUN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
        S_RUN: begin
          cnt_next = '0;
          if (soft_rst_req) begin
            state_next = S_SOFT;
          end
        end
        S_SOFT: begin
          // The hold interval only starts counting once the request is withdrawn.
          if (soft_rst_req) begin
            cnt_next = '0;
          end else if (cnt_reg == STAGE_LAST) begin
            state_next = S_CORE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
        default: begin
          state_next = S_HOLD;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_comb begin
    core_next   = (state_next == S_CORE) || (state_next == S_PERIPH) || (state_next == S_RUN);
    periph_next = (state_next == S_PERIPH) || (state_next == S_RUN);
    ready_next  = (state_next == S_RUN);
  end

  always_ff @(posedge clk_in1 or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= S_HOLD;
      cnt_reg     <= '0;
      core_rstn   <= 1'b0;
      periph_rstn <= 1'b0;
      ready       <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      core_rstn   <= core_next;
      periph_rstn <= periph_next;
      ready       <= ready_next;
    end
  end

  assign state_o = state_reg;

`ifdef LOCK_LOSS_COUNTER_EN
  logic       loss_event;
  logic [7:0] loss_cnt_reg;

  assign loss_event = lock_lost && (state_reg <= S_SOFT);

  always_ff @(posedge clk_in1 or negedge resetn) begin
    if (!resetn) begin
      loss_cnt_reg <= 8'd0;
    end else if (loss_event && (loss_cnt_reg != 8'hFF)) begin
      loss_cnt_reg <= loss_cnt_reg + 8'd1;
    end
  end

  assign lock_loss_cnt = loss_cnt_reg;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Randomized bench for pll_reset_sequencer against a phase/countdown reference model.
// Define LOCK_LOSS_COUNTER_EN to also exercise lock_loss_cnt.
module tb_pll_reset_sequencer;

  localparam int SYNC   = 2;
  localparam int STABLE = 8;
  localparam int DELAY  = 4;

  localparam int P_HOLD = 0, P_STABLE = 1, P_CORE = 2, P_PERIPH = 3, P_RUN = 4, P_SOFT = 5;

  logic       clk_in1 = 1'b0;
  logic       resetn = 1'b0;
  logic       locked = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic       core_rstn, periph_rstn, ready;
  logic [2:0] state_o;
`ifdef LOCK_LOSS_COUNTER_EN
  logic [7:0] lock_loss_cnt;
`endif

  int tests = 0;
  int fails = 0;
  int edge_n = 0;

  // Reference model: lock delay line, named phase, cycles remaining in the phase.
  int m_phase;
  int m_rem;
  int m_loss;
  bit m_pipe[$];

  always #5 clk_in1 = ~clk_in1;

  pll_reset_sequencer #(
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STABLE),
    .STAGE_DELAY  (DELAY),
    .CNT_W        (16)
  ) dut (
    .clk_in1     (clk_in1),
    .resetn      (resetn),
    .locked      (locked),
    .soft_rst_req(soft_rst_req),
    .core_rstn   (core_rstn),
    .periph_rstn (periph_rstn),
    .ready       (ready),
    .state_o     (state_o)
`ifdef LOCK_LOSS_COUNTER_EN
    ,
    .lock_loss_cnt(lock_loss_cnt)
`endif
  );

  function automatic void model_reset();
    m_pipe = {};
    for (int i = 0; i < SYNC; i++) m_pipe.push_back(1'b0);
    m_phase = P_HOLD;
    m_rem   = 0;
    m_loss  = 0;
  endfunction

  function automatic void model_step(input bit lk, input bit sr);
    bit ls;
    ls = m_pipe.pop_front();
    m_pipe.push_back(lk);
    if (m_phase != P_HOLD && !ls) begin
      if (m_loss < 255) m_loss++;
      m_phase = P_HOLD;
    end else begin
      case (m_phase)
        P_HOLD: if (ls) begin m_phase = P_STABLE; m_rem = STABLE; end
        P_STABLE: begin
          m_rem--;
          if (m_rem == 0) begin m_phase = P_CORE; m_rem = DELAY; end
        end
        P_CORE, P_PERIPH: begin
          if (sr) begin
            m_phase = P_SOFT; m_rem = DELAY;
          end else begin
            m_rem--;
            if (m_rem == 0) begin m_phase = m_phase + 1; m_rem = DELAY; end
          end
        end
        P_RUN: if (sr) begin m_phase = P_SOFT; m_rem = DELAY; end
        default: begin
          if (sr) m_rem = DELAY;
          else begin
            m_rem--;
            if (m_rem == 0) begin m_phase = P_CORE; m_rem = DELAY; end
          end
        end
      endcase
    end
  endfunction

  function automatic logic [5:0] m_exp();
    logic c, p, r;
    c = (m_phase == P_CORE) || (m_phase == P_PERIPH) || (m_phase == P_RUN);
    p = (m_phase == P_PERIPH) || (m_phase == P_RUN);
    r = (m_phase == P_RUN);
    return {c, p, r, 3'(m_phase)};
  endfunction

  // One clock edge with the model advanced on the same sampled inputs; returns 1ns after the edge.
  task automatic tick();
    @(posedge clk_in1);
    edge_n++;
    model_step(locked, soft_rst_req);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    soft_rst_req = 1'b0;
    locked = 1'b0;
    @(posedge clk_in1);
    @(posedge clk_in1);
    #1;
    resetn = 1'b1;
    model_reset();
    edge_n = 0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    locked = 1'b1;
    soft_rst_req = 1'b1;
    repeat (3) begin
      @(posedge clk_in1);
      #1;
      tests++;
      if ({core_rstn, periph_rstn, ready, state_o} !== 6'b000_000) begin
        fails++;
        $display("FAIL reset_state: got %b want 000000", {core_rstn, periph_rstn, ready, state_o});
      end
    end
`ifdef LOCK_LOSS_COUNTER_EN
    tests++;
    if (lock_loss_cnt !== 8'd0) begin
      fails++;
      $display("FAIL reset_loss_cnt: got %0d want 0", lock_loss_cnt);
    end
`endif
    $display("[TB] reset: outputs held low with locked and soft_rst_req high");
  endtask

  task automatic test_power_up();
    int core_e, per_e, rdy_e, stab_e;
    core_e = -1; per_e = -1; rdy_e = -1; stab_e = -1;
    do_reset();
    locked = 1'b1;
    repeat (24) begin
      tick();
      tests++;
      if ({core_rstn, periph_rstn, ready, state_o} !== m_exp()) begin
        fails++;
        $display("FAIL power_up edge %0d: got %b want %b", edge_n, {core_rstn, periph_rstn, ready, state_o}, m_exp());
      end
      if (state_o == 3'd1 && stab_e < 0) stab_e = edge_n;
      if (core_rstn && core_e < 0) core_e = edge_n;
      if (periph_rstn && per_e < 0) per_e = edge_n;
      if (ready && rdy_e < 0) rdy_e = edge_n;
    end
    tests++;
    if (stab_e !== SYNC + 1) begin fails++; $display("FAIL power_up_stable_edge: got %0d want %0d", stab_e, SYNC + 1); end
    tests++;
    if (core_e !== 11) begin fails++; $display("FAIL power_up_core_edge: got %0d want 11", core_e); end
    tests++;
    if (per_e !== 15) begin fails++; $display("FAIL power_up_periph_edge: got %0d want 15", per_e); end
    tests++;
    if (rdy_e !== 19) begin fails++; $display("FAIL power_up_ready_edge: got %0d want 19", rdy_e); end
    $display("[TB] power_up: stable@%0d core@%0d periph@%0d ready@%0d", stab_e, core_e, per_e, rdy_e);
  endtask

  // Drop locked for len cycles, first sampled low at edge s+1; count restarts from re-lock.
  task automatic glitch_run(input int s, input int len, input int want_core);
    int core_e;
    core_e = -1;
    do_reset();
    locked = 1'b1;
    repeat (40) begin
      tick();
      tests++;
      if ({core_rstn, periph_rstn, ready, state_o} !== m_exp()) begin
        fails++;
        $display("FAIL stable_glitch edge %0d: got %b want %b", edge_n, {core_rstn, periph_rstn, ready, state_o}, m_exp());
      end
      if (core_rstn && core_e < 0) core_e = edge_n;
      if (edge_n == s) locked = 1'b0;
      if (edge_n == s + len) locked = 1'b1;
    end
    tests++;
    if (core_e !== want_core) begin
      fails++;
      $display("FAIL stable_glitch_core_edge s=%0d len=%0d: got %0d want %0d", s, len, core_e, want_core);
    end
    $display("[TB] stable_glitch: drop after edge %0d for %0d cycles, core@%0d", s, len, core_e);
  endtask

  task automatic test_stable_glitch();
    int s, len;
    glitch_run(6, 3, 20);
    for (int i = 0; i < 4; i++) begin
      s = $urandom_range(3, 8);
      len = $urandom_range(1, 4);
      glitch_run(s, len, s + len + 1 + SYNC + STABLE - 1 + 1);
    end
  endtask

  task automatic test_lock_loss_run();
    int k;
    do_reset();
    locked = 1'b1;
    for (int it = 0; it < 3; it++) begin
      repeat (20 + $urandom_range(0, 5)) begin
        tick();
        tests++;
        if ({core_rstn, periph_rstn, ready, state_o} !== m_exp()) begin
          fails++;
          $display("FAIL lock_loss_run edge %0d: got %b want %b", edge_n, {core_rstn, periph_rstn, ready, state_o}, m_exp());
        end
      end
      locked = 1'b0;
      tick();
      k = edge_n;
      tick();
      tests++;
      if ({core_rstn, periph_rstn, ready, state_o} !== 6'b111_100) begin
        fails++;
        $display("FAIL lock_loss_k+1: got %b want 111100", {core_rstn, periph_rstn, ready, state_o});
      end
      tick();
      tests++;
      if ({core_rstn, periph_rstn, ready, state_o} !== 6'b000_000) begin
        fails++;
        $display("FAIL lock_loss_k+2: got %b want 000000", {core_rstn, periph_rstn, ready, state_o});
      end
      $display("[TB] lock_loss: locked low sampled at edge %0d, outputs %b at edge %0d", k, {core_rstn, periph_rstn, ready}, edge_n);
      repeat ($urandom_range(1, 4)) tick();
      locked = 1'b1;
    end
  endtask

  task automatic test_soft_reset();
    int dur, last_hi, core_e, per_e, rdy_e;
    do_reset();
    locked = 1'b1;
    repeat (20) tick();
    for (int it = 0; it < 3; it++) begin
      dur = (it == 0) ? 6 : $urandom_range(1, 8);
      soft_rst_req = 1'b1;
      tick();
      tests++;
      if ({core_rstn, periph_rstn, ready, state_o} !== 6'b000_101) begin
        fails++;
        $display("FAIL soft_enter: got %b want 000101", {core_rstn, periph_rstn, ready, state_o});
      end
      repeat (dur - 1) tick();
      last_hi = edge_n;
      soft_rst_req = 1'b0;
      core_e = -1; per_e = -1; rdy_e = -1;
      repeat (16) begin
        tick();
        tests++;
        if ({core_rstn, periph_rstn, ready, state_o} !== m_exp()) begin
          fails++;
          $display("FAIL soft_seq edge %0d: got %b want %b", edge_n, {core_rstn, periph_rstn, ready, state_o}, m_exp());
        end
        if (core_rstn && core_e < 0) core_e = edge_n - last_hi;
        if (periph_rstn && per_e < 0) per_e = edge_n - last_hi;
        if (ready && rdy_e < 0) rdy_e = edge_n - last_hi;
      end
      tests++;
      if (core_e !== DELAY || per_e !== 2 * DELAY || rdy_e !== 3 * DELAY) begin
        fails++;
        $display("FAIL soft_release: got core+%0d periph+%0d ready+%0d want +%0d +%0d +%0d",
                 core_e, per_e, rdy_e, DELAY, 2 * DELAY, 3 * DELAY);
      end
      $display("[TB] soft_reset: %0d cycles, core+%0d periph+%0d ready+%0d", dur, core_e, per_e, rdy_e);
    end
    // Requests during lock qualification are ignored.
    do_reset();
    locked = 1'b1;
    core_e = -1;
    repeat (14) begin
      tick();
      if (edge_n == 4) soft_rst_req = 1'b1;
      if (edge_n == 7) soft_rst_req = 1'b0;
      if (core_rstn && core_e < 0) core_e = edge_n;
    end
    tests++;
    if (core_e !== 11) begin fails++; $display("FAIL soft_in_stable_core_edge: got %0d want 11", core_e); end
    $display("[TB] soft_in_stable: core@%0d", core_e);
  endtask

  task automatic test_async_reset();
    int core_e, per_e, rdy_e;
    do_reset();
    locked = 1'b1;
    repeat (16) tick();
    #2;
    resetn = 1'b0;
    #1;
    tests++;
    if ({core_rstn, periph_rstn, ready, state_o} !== 6'b000_000) begin
      fails++;
      $display("FAIL async_reset: got %b want 000000", {core_rstn, periph_rstn, ready, state_o});
    end
    @(posedge clk_in1);
    #1;
    resetn = 1'b1;
    model_reset();
    edge_n = 0;
    core_e = -1; per_e = -1; rdy_e = -1;
    repeat (22) begin
      tick();
      tests++;
      if ({core_rstn, periph_rstn, ready, state_o} !== m_exp()) begin
        fails++;
        $display("FAIL async_restart edge %0d: got %b want %b", edge_n, {core_rstn, periph_rstn, ready, state_o}, m_exp());
      end
      if (core_rstn && core_e < 0) core_e = edge_n;
      if (periph_rstn && per_e < 0) per_e = edge_n;
      if (ready && rdy_e < 0) rdy_e = edge_n;
    end
    tests++;
    if (core_e !== 11 || per_e !== 15 || rdy_e !== 19) begin
      fails++;
      $display("FAIL async_restart_edges: got %0d/%0d/%0d want 11/15/19", core_e, per_e, rdy_e);
    end
    $display("[TB] async_reset: mid-periph reset, restart core@%0d periph@%0d ready@%0d", core_e, per_e, rdy_e);
  endtask

`ifdef LOCK_LOSS_COUNTER_EN
  task automatic test_lock_loss_cnt();
    do_reset();
    for (int it = 0; it < 3; it++) begin
      locked = 1'b1;
      repeat (21) tick();
      if (it == 1) begin
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        repeat (14) tick();
      end
      locked = 1'b0;
      repeat (4) tick();
    end
    tests++;
    if (lock_loss_cnt !== 8'd3) begin fails++; $display("FAIL loss_cnt_3: got %0d want 3", lock_loss_cnt); end
    $display("[TB] lock_loss_cnt: 3 losses + 1 soft -> %0d", lock_loss_cnt);
    for (int it = 0; it < 300; it++) begin
      locked = 1'b1;
      repeat (4) tick();
      locked = 1'b0;
      repeat (3) tick();
      tests++;
      if (lock_loss_cnt !== 8'(m_loss)) begin
        fails++;
        $display("FAIL loss_cnt_track it=%0d: got %0d want %0d", it, lock_loss_cnt, m_loss);
      end
    end
    tests++;
    if (lock_loss_cnt !== 8'd255) begin fails++; $display("FAIL loss_cnt_sat: got %0d want 255", lock_loss_cnt); end
    $display("[TB] lock_loss_cnt: 303 losses -> %0d", lock_loss_cnt);
  endtask
`endif

  task automatic test_random();
    do_reset();
    repeat (1500) begin
      if (locked) begin
        if ($urandom_range(0, 39) == 0) locked = 1'b0;
      end else if ($urandom_range(0, 5) == 0) begin
        locked = 1'b1;
      end
      if ($urandom_range(0, 29) == 0) soft_rst_req = ~soft_rst_req;
      tick();
      tests++;
      if ({core_rstn, periph_rstn, ready, state_o} !== m_exp()) begin
        fails++;
        $display("FAIL random edge %0d: got %b want %b", edge_n, {core_rstn, periph_rstn, ready, state_o}, m_exp());
      end
`ifdef LOCK_LOSS_COUNTER_EN
      tests++;
      if (lock_loss_cnt !== 8'(m_loss)) begin
        fails++;
        $display("FAIL random_loss_cnt edge %0d: got %0d want %0d", edge_n, lock_loss_cnt, m_loss);
      end
`endif
    end
    $display("[TB] random: 1500 cycles, final state %0d", state_o);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_power_up();
    test_stable_glitch();
    test_lock_loss_run();
    test_soft_reset();
    test_async_reset();
`ifdef LOCK_LOSS_COUNTER_EN
    test_lock_loss_cnt();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
